// File: rtl/cnn_pkg.sv
// Shared CNN definitions: conv2 feature-map geometry, serialiser FSM states and the ReLU helper.
package cnn_pkg;

  typedef enum logic [1:0] {FILL, DRAIN, DONE} fmap_state_t;

  localparam int unsigned CONV2_OUT_W     = 8;
  localparam int unsigned CONV2_OUT_H     = 8;
  localparam int unsigned CONV2_CH        = 3;
  localparam int unsigned CONV2_DATA_BITS = 12;

  // Clamp negative two's-complement words to zero.
  function automatic logic [CONV2_DATA_BITS-1:0] relu(input logic [CONV2_DATA_BITS-1:0] word);
    return word[CONV2_DATA_BITS-1] ? '0 : word;
  endfunction

endpackage

// File: rtl/fmap_ram.sv
// Frame store: CH-lane simple dual-port RAM. One full-width write port, one lane-selected read
// port with registered read data that holds its value while re_i is low.
module fmap_ram #(
  parameter int unsigned CH        = 3,
  parameter int unsigned DATA_BITS = 12,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned AddrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int unsigned SelW      = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [AddrW-1:0]        waddr_i,
  input  logic [CH*DATA_BITS-1:0] wdata_i,
  input  logic                    re_i,
  input  logic [AddrW-1:0]        raddr_i,
  input  logic [SelW-1:0]         rsel_i,
  output logic [DATA_BITS-1:0]    rdata_o
);

  logic [CH*DATA_BITS-1:0] mem_q [DEPTH];
  logic [DATA_BITS-1:0]    rdata_q;

  // Write all lanes of one pixel position.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered lane-selected read; holds when not enabled so the pipeline can stall.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i][rsel_i*DATA_BITS +: DATA_BITS];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/conv2_fmap_ser.sv
// conv2 feature-map serialiser: fills a frame store with CH-wide result beats, then streams it
// out one word per handshake in channel-major, row-major order.
// Build option: CONV2_FMAP_SER_RELU_EN clamps negative output words to zero.
module conv2_fmap_ser
  import cnn_pkg::*;
#(
  parameter int unsigned OUT_W     = CONV2_OUT_W,
  parameter int unsigned OUT_H     = CONV2_OUT_H,
  parameter int unsigned CH        = CONV2_CH,
  parameter int unsigned DATA_BITS = CONV2_DATA_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [CH*DATA_BITS-1:0] data_in,
  output logic                    in_ready,
  output logic [DATA_BITS-1:0]    data_out,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic                    frame_done,
  output logic                    overflow
);

  localparam int unsigned NPix = OUT_W * OUT_H;
  localparam int unsigned PixW = (NPix > 1) ? $clog2(NPix) : 1;
  localparam int unsigned ChW  = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [PixW-1:0] LastPix = PixW'(NPix - 1);
  localparam logic [ChW-1:0]  LastCh  = ChW'(CH - 1);

  fmap_state_t          state_q;
  logic [PixW-1:0]      wr_idx_q;
  logic [PixW-1:0]      rd_pix_q;
  logic [ChW-1:0]       rd_ch_q;
  logic                 in_ready_q;
  logic                 s1_valid_q;  // RAM read register holds a word not yet in data_out
  logic                 valid_out_q;
  logic [DATA_BITS-1:0] data_out_q;
  logic                 frame_done_q;
  logic                 overflow_q;

  logic                 wr_en;
  logic                 fill_last;
  logic                 out_load;
  logic                 more_reads;
  logic                 rd_en;
  logic                 last_accept;
  logic [DATA_BITS-1:0] rd_data;
  logic [DATA_BITS-1:0] word_out;

  fmap_ram #(
    .CH        (CH),
    .DATA_BITS (DATA_BITS),
    .DEPTH     (NPix)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (wr_idx_q),
    .wdata_i (data_in),
    .re_i    (rd_en),
    .raddr_i (rd_pix_q),
    .rsel_i  (rd_ch_q),
    .rdata_o (rd_data)
  );

  // Handshake decode and read-issue control.
  always_comb begin
    wr_en     = valid_in && in_ready_q;
    fill_last = wr_en && (wr_idx_q == LastPix);
    out_load  = !valid_out_q || ready_out;
    // The first read is issued on the last fill beat, so inside DRAIN the read pointer is back
    // at (0,0) only once every word of the frame has been issued.
    more_reads  = (state_q == DRAIN) && ((rd_pix_q != '0) || (rd_ch_q != '0));
    rd_en       = fill_last || (more_reads && (!s1_valid_q || out_load));
    last_accept = (state_q == DRAIN) && valid_out_q && ready_out && !s1_valid_q && !more_reads;
  end

  // Output-side word transform.
  always_comb begin
`ifdef CONV2_FMAP_SER_RELU_EN
    word_out = relu(rd_data);
`else
    word_out = rd_data;
`endif
  end

  // FSM, counters, read pipeline and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FILL;
      wr_idx_q     <= '0;
      rd_pix_q     <= '0;
      rd_ch_q      <= '0;
      in_ready_q   <= 1'b0;
      s1_valid_q   <= 1'b0;
      valid_out_q  <= 1'b0;
      data_out_q   <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;

      if (valid_in && !in_ready_q) begin
        overflow_q <= 1'b1;
      end

      if (wr_en) begin
        wr_idx_q <= fill_last ? '0 : wr_idx_q + 1'b1;
      end

      if (rd_en) begin
        if (rd_pix_q == LastPix) begin
          rd_pix_q <= '0;
          rd_ch_q  <= (rd_ch_q == LastCh) ? '0 : rd_ch_q + 1'b1;
        end else begin
          rd_pix_q <= rd_pix_q + 1'b1;
        end
      end

      if (rd_en) begin
        s1_valid_q <= 1'b1;
      end else if (out_load) begin
        s1_valid_q <= 1'b0;
      end

      if (out_load) begin
        valid_out_q <= s1_valid_q;
        if (s1_valid_q) begin
          data_out_q <= word_out;
        end
      end

      unique case (state_q)
        FILL: begin
          if (fill_last) begin
            state_q    <= DRAIN;
            in_ready_q <= 1'b0;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (last_accept) begin
            state_q      <= DONE;
            frame_done_q <= 1'b1;
          end
        end
        DONE: begin
          state_q    <= FILL;
          in_ready_q <= 1'b1;
        end
        default: begin
          state_q <= FILL;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign data_out   = data_out_q;
  assign valid_out  = valid_out_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_conv2_fmap_ser.sv
// Self-checking bench for conv2_fmap_ser: a frame-level model in the monitor predicts in_ready,
// overflow, the emitted word stream and frame_done, and a few literal values pin the model.
module tb_conv2_fmap_ser;

  localparam int NP = 64;
  localparam int NC = 3;
  localparam int DB = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_in;
  logic [NC*DB-1:0] data_in;
  logic             in_ready;
  logic [DB-1:0]    data_out;
  logic             valid_out;
  logic             ready_out;
  logic             frame_done;
  logic             overflow;

  conv2_fmap_ser dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .in_ready   (in_ready),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready_out  (ready_out),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int rmode = 0;        // 0: always ready, 1: 1,0,0,1 pattern, 2: random
  bit t5_arm = 1'b0;
  bit rst_req = 1'b0;
  int fd_cnt = 0;
  logic [DB-1:0] acc_log [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DB-1:0] relu_m(input logic [DB-1:0] w);
`ifdef CONV2_FMAP_SER_RELU_EN
    if ($signed(w) < 0) return '0;
`endif
    return w;
  endfunction

  // Downstream ready generator.
  initial begin
    int ph = 0;
    ready_out = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        1: begin ready_out = (ph == 0) || (ph == 3); ph = (ph + 1) % 4; end
        2: ready_out = ($urandom_range(0, 3) != 0);
        default: ready_out = 1'b1;
      endcase
    end
  end

  // Monitor: frame-level model plus per-cycle comparison.
  initial begin
    logic [DB-1:0] mem_m [NC][NP];
    logic [DB-1:0] exp_q [$];
    logic [DB-1:0] hold_d;
    logic [DB-1:0] popped;
    bit busy = 0, skip = 1, exp_ovf = 0, fd_pending = 0, done_now, hold_v = 0;
    bit first_pending = 0, exp_ready;
    int beat_cnt = 0, frame_acc = 0, cyc = 0, last_beat_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("rst_valid_out", valid_out, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_in_ready", in_ready, 0);
        exp_q.delete();
        busy = 0; skip = 1; exp_ovf = 0; fd_pending = 0; hold_v = 0;
        first_pending = 0; beat_cnt = 0; frame_acc = 0;
      end else begin
        exp_ready = !busy && !skip;
        if (!skip) chk("in_ready", in_ready, exp_ready);
        chk("overflow", overflow, exp_ovf);
        chk("frame_done", frame_done, fd_pending);
        if (frame_done) fd_cnt++;
        done_now = fd_pending;
        fd_pending = 0;
        if (hold_v) begin
          chk("stall_valid", valid_out, 1);
          chk("stall_data", data_out, hold_d);
        end
        hold_v = 0;
        if (valid_out) begin
          if (first_pending) begin
            chk("first_latency", cyc - last_beat_cyc, 2);
            first_pending = 0;
          end
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_word: got %0h expected no word at %0t", data_out, $time);
          end else begin
            chk("data_out", data_out, exp_q[0]);
            if (ready_out) begin
              acc_log.push_back(data_out);
              popped = exp_q.pop_front();
              frame_acc++;
              if (t5_arm && frame_acc == 71) rst_req = 1'b1;
              if (frame_acc == NC * NP) begin
                frame_acc = 0;
                fd_pending = 1;
              end
            end else begin
              hold_v = 1;
              hold_d = data_out;
            end
          end
        end
        if (valid_in && !exp_ready) exp_ovf = 1;
        if (valid_in && exp_ready) begin
          for (int c = 0; c < NC; c++) mem_m[c][beat_cnt] = data_in[c*DB +: DB];
          beat_cnt++;
          if (beat_cnt == NP) begin
            beat_cnt = 0;
            busy = 1;
            last_beat_cyc = cyc;
            first_pending = 1;
            for (int c = 0; c < NC; c++)
              for (int p = 0; p < NP; p++) exp_q.push_back(relu_m(mem_m[c][p]));
          end
        end
        if (done_now) busy = 0;
        skip = 0;
      end
    end
  end

  // kind 0: ramp 100*c+pos; 1: random; 2: random with 12'hF38 on ch0 pos0.
  task automatic send_frame(input int kind);
    for (int p = 0; p < NP; p++) begin
      int guard = 0;
      @(posedge clk); #1;
      while (!in_ready && guard < 3000) begin
        valid_in = 1'b0;
        @(posedge clk); #1;
        guard++;
      end
      if (!in_ready) begin
        checks++; failures++;
        $display("FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
        valid_in = 1'b0;
        return;
      end
      for (int c = 0; c < NC; c++) begin
        if (kind == 0) data_in[c*DB +: DB] = DB'(100 * c + p);
        else data_in[c*DB +: DB] = DB'($urandom);
      end
      if (kind == 2 && p == 0) data_in[0 +: DB] = 12'hF38;
      valid_in = 1'b1;
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_fd(input int target);
    int guard = 0;
    while (fd_cnt < target && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    chk("frame_done_reached", (fd_cnt >= target), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    rst = 1'b1; valid_in = 1'b0; data_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // T1 ramp, no backpressure
    rmode = 0; acc_log.delete(); base = fd_cnt;
    send_frame(0);
    wait_fd(base + 1);
    chk("t1_count", acc_log.size(), 192);
    chk("t1_w0", acc_log[0], 0);
    chk("t1_w64", acc_log[64], 100);
    chk("t1_w191", acc_log[191], 263);

    // T2 ramp with 1,0,0,1 backpressure
    rmode = 1; acc_log.delete(); base = fd_cnt;
    send_frame(0);
    wait_fd(base + 1);
    chk("t2_count", acc_log.size(), 192);
    chk("t2_w100", acc_log[100], 136);
    chk("t2_w150", acc_log[150], 222);

    // T3 writes attempted during drain
    rmode = 0; acc_log.delete(); base = fd_cnt;
    send_frame(1);
    repeat (4) begin @(posedge clk); #1; end
    repeat (5) begin
      valid_in = 1'b1; data_in = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    wait_fd(base + 1);
    chk("t3_overflow", overflow, 1);
    chk("t3_count", acc_log.size(), 192);

    // T4 back-to-back frames, random backpressure
    rmode = 2; acc_log.delete(); base = fd_cnt;
    send_frame(1);
    send_frame(1);
    wait_fd(base + 2);
    chk("t4_pulses", fd_cnt - base, 2);
    chk("t4_count", acc_log.size(), 384);

    // T5 reset after word 70 is accepted
    rmode = 0; t5_arm = 1'b1;
    send_frame(0);
    for (int i = 0; i < 3000 && !rst_req; i++) begin @(negedge clk); #1; end
    chk("t5_rst_req", rst_req, 1);
    @(posedge clk); #1 rst = 1'b1;
    t5_arm = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; rst_req = 1'b0;
    acc_log.delete(); base = fd_cnt;
    send_frame(0);
    wait_fd(base + 1);
    chk("t5_count", acc_log.size(), 192);
    chk("t5_w0", acc_log[0], 0);
    chk("t5_overflow", overflow, 0);

    // T6 negative word on ch0 pos0
    rmode = 1; acc_log.delete(); base = fd_cnt;
    send_frame(2);
    wait_fd(base + 1);
`ifdef CONV2_FMAP_SER_RELU_EN
    chk("t6_relu", acc_log[0], 12'h000);
`else
    chk("t6_relu", acc_log[0], 12'hF38);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
